mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage requester that drives the data memory (1-cycle registered-read RAM; word-addressed, word-wide).
//  Converts pipeline load/store requests (byte/half/word, signed/unsigned) into RAM read/write strobes.
//  Implements sub-word stores as read-modify-write. Aligns and extends load data.
//  Sits between EX/MEM pipeline register and data memory; o_busy stalls the pipeline.
// PARAMETERS
//  B  32  data width in bits (fixed at 32 for lane logic)
//  W  5   RAM word-address bits; RAM word index = i_req_addr[W+1:2]
// PORTS
//  i_clk           in   1   clock, rising edge
//  i_reset_n       in   1   synchronous reset, active-low
//  i_req_valid     in   1   request present
//  o_req_ready     out  1   unit idle; request transfers when valid&&ready
//  i_req_write     in   1   1=store, 0=load
//  i_req_size      in   2   00=byte 01=half 10=word (11 treated as word)
//  i_req_unsigned  in   1   zero-extend loads (LBU/LHU); ignored for stores/words
//  i_req_addr      in   B   byte address
//  i_req_wdata     in   B   store data, right-justified
//  o_rsp_valid     out  1   one-cycle pulse: request complete
//  o_rsp_rdata     out  B   aligned/extended load data; 0 for stores and errors
//  o_rsp_misalign  out  1   qualifies o_rsp_valid: misaligned access (macro-dependent)
//  o_busy          out  1   state != IDLE
//  o_mem_read      out  1   RAM read strobe
//  o_mem_write     out  1   RAM write strobe
//  o_mem_addr      out  W   RAM word address
//  o_mem_wdata     out  B   RAM write data
//  i_mem_rdata     in   B   RAM read data, valid exactly one cycle after o_mem_read (RAM clears it to 0 otherwise)
// BEHAVIOUR
//  FSM states (Moore; mem strobes/addr/wdata decoded from state + latched request regs):
//   IDLE    ready=1. Accept: latch addr/size/unsigned/wdata. load->LD_RD; word store->ST_WR;
//           byte/half store->RMW_RD; misaligned (when checked)->RESP with misalign=1, no RAM access.
//   LD_RD   o_mem_read=1 -> LD_CAP
//   LD_CAP  capture i_mem_rdata; extract lane, extend -> RESP
//   ST_WR   o_mem_write=1, o_mem_wdata=latched wdata -> RESP
//   RMW_RD  o_mem_read=1 -> RMW_MRG
//   RMW_MRG merge latched byte/half into i_mem_rdata -> merge reg -> RMW_WR
//   RMW_WR  o_mem_write=1, o_mem_wdata=merge reg -> RESP
//   RESP    o_rsp_valid=1 one cycle -> IDLE (no back-to-back accept in RESP)
//  Latency accept->o_rsp_valid: load 3, word store 2, sub-word store 4, misaligned 1.
//  o_mem_read and o_mem_write never both high. o_mem_addr held stable across RMW_RD..RMW_WR.
//  Little-endian: byte lane addr[1:0] (lane0=[7:0]); half lane addr[1] (0=[15:0]).
//  Loads: byte/half sign-extended from lane MSB unless i_req_unsigned; word passes through.
//  Stores: only selected lane(s) change; other bytes preserved from RAM read.
//  Requests with valid while busy are not accepted; requester holds them until ready.
//  Reset (i_reset_n=0 at edge): state->IDLE; o_rsp_valid, o_rsp_misalign, o_busy, o_mem_read, o_mem_write=0;
//   o_rsp_rdata, o_mem_addr, o_mem_wdata, latched regs=0; o_req_ready=1 after reset.
//   Reset mid-RMW before RMW_WR: no write issued. Write strobe visible in the reset cycle still commits
//   (RAM samples same edge); no response is issued for the aborted request.
// CONFIGURATION
//  MEM_ACCESS_MISALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> RESP, misalign=1, rdata=0.
//  Not defined: no check; o_rsp_misalign tied 0; low address bits below access size masked to 0 (force-aligned).
// STRUCTURE
//  mem_access_defs.vh: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encodings, lane constants.
//  Sub-module mem_lane_align (combinational): load extract/extend and store merge by size/addr[1:0].
//  Top holds FSM, request latches, response and merge registers.
// TESTING
//  LB addr 0x07, RAM word1=0x80FF_1234 -> RAM read word 1; rsp 3 cycles later rdata=0xFFFF_FF80.
//  LBU same addr -> rdata=0x0000_0080; LH addr 0x04 -> 0x0000_1234; LW addr 0x04 -> 0x80FF_1234.
//  SB addr 0x05 wdata 0xAB over 0x1122_3344 -> read, write 0x1122_AB44; rsp at +4; o_busy high 4 cycles.
//  SW addr 0x08 wdata 0xDEAD_BEEF -> single write cycle at +1, rsp at +2; no read strobe.
//  LW addr 0x06 with macro -> rsp at +1, misalign=1, rdata=0, no RAM strobes; without macro -> reads word 1.
//  Reset asserted during RMW_MRG -> no write, no rsp; RAM word unchanged; ready=1 after reset.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit.
// Contains the access-size encodings, the FSM state encodings and the lane widths.
package mem_access_unit_pkg;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_MRG,
        RMW_WR,
        RESP
    } state_e;

    // Encoding 2'b11 is not a real size; it behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] raw);
        return (raw == 2'b11) ? SZ_WORD : size_e'(raw);
    endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational little-endian lane logic for the MEM-stage access unit.
// Extracts and extends load lanes, and merges sub-word store data into a RAM word.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  size_e             size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [DATA_W-1:0] merge_data_o
);
    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: BYTE_W];
    assign half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: HALF_W];

    // NOTE: every output is given a default before the case, so no path can infer a latch.
    always_comb begin
        load_data_o  = rdata_i;
        merge_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o  = {{(DATA_W-BYTE_W){byte_lane[BYTE_W-1] & ~unsigned_i}}, byte_lane};
                merge_data_o = rdata_i;
                merge_data_o[{addr_lo_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_data_o  = {{(DATA_W-HALF_W){half_lane[HALF_W-1] & ~unsigned_i}}, half_lane};
                merge_data_o = rdata_i;
                merge_data_o[{addr_lo_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage requester: turns load/store requests into RAM strobes, with read-modify-write for sub-word stores.
// Optional feature macro MEM_ACCESS_MISALIGN_CHECK_EN: flag misaligned half/word accesses instead of force-aligning.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_write,
    input  logic [1:0]   i_req_size,
    input  logic         i_req_unsigned,
    input  logic [B-1:0] i_req_addr,
    input  logic [B-1:0] i_req_wdata,
    output logic         o_rsp_valid,
    output logic [B-1:0] o_rsp_rdata,
    output logic         o_rsp_misalign,
    output logic         o_busy,
    output logic         o_mem_read,
    output logic         o_mem_write,
    output logic [W-1:0] o_mem_addr,
    output logic [B-1:0] o_mem_wdata,
    input  logic [B-1:0] i_mem_rdata
);
    state_e       state_q, state_d;
    size_e        req_size, size_q;
    logic [W+1:0] req_addr, addr_q;
    logic         unsigned_q;
    logic [B-1:0] wdata_q, merge_q, rsp_rdata_q;
    logic [B-1:0] load_data, merge_data;
    logic         accept, req_misalign;
    logic         unused_addr_hi;

    assign unused_addr_hi = ^i_req_addr[B-1:W+2];
    assign req_size       = norm_size(i_req_size);
    assign accept         = i_req_valid && (state_q == IDLE);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic misalign_q;

    assign req_misalign = ((req_size == SZ_HALF) && i_req_addr[0]) ||
                          ((req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
    assign req_addr     = i_req_addr[W+1:0];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)  misalign_q <= 1'b0;
        else if (accept) misalign_q <= req_misalign;
    end

    assign o_rsp_misalign = (state_q == RESP) && misalign_q;
`else
    // Without the check, address bits below the access size are dropped.
    assign req_misalign = 1'b0;

    always_comb begin
        req_addr = i_req_addr[W+1:0];
        if (req_size == SZ_HALF)      req_addr[0]   = 1'b0;
        else if (req_size == SZ_WORD) req_addr[1:0] = 2'b00;
    end

    assign o_rsp_misalign = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    if (req_misalign)             state_d = RESP;
                    else if (!i_req_write)        state_d = LD_RD;
                    else if (req_size == SZ_WORD) state_d = ST_WR;
                    else                          state_d = RMW_RD;
                end
            end
            LD_RD:   state_d = LD_CAP;
            LD_CAP:  state_d = RESP;
            ST_WR:   state_d = RESP;
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state_q == IDLE);
        o_busy      = (state_q != IDLE);
        o_rsp_valid = (state_q == RESP);
        o_mem_read  = (state_q == LD_RD) || (state_q == RMW_RD);
        o_mem_write = (state_q == ST_WR) || (state_q == RMW_WR);
        o_mem_wdata = '0;
        if (state_q == ST_WR)       o_mem_wdata = wdata_q;
        else if (state_q == RMW_WR) o_mem_wdata = merge_q;
    end

    assign o_mem_addr  = addr_q[W+1:2];
    assign o_rsp_rdata = rsp_rdata_q;

    // Response data is cleared on accept so stores and flagged accesses answer with zero.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
            merge_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q      <= req_addr;
                size_q      <= req_size;
                unsigned_q  <= i_req_unsigned;
                wdata_q     <= i_req_wdata;
                rsp_rdata_q <= '0;
            end
            if (state_q == LD_CAP)  rsp_rdata_q <= load_data;
            if (state_q == RMW_MRG) merge_q     <= merge_data;
        end
    end

    mem_lane_align u_lane_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .rdata_i      (i_mem_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors, reset cases, held requests and random traffic.
// A word-level array model computes expected responses, latencies and RAM contents.
module tb_mem_access_unit;
    localparam int B = 32;
    localparam int W = 5;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  lat;
        logic [3:0]  busy;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  nrd;
        logic [3:0]  nwr;
        logic        both;
    } obs_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] lit;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [1:0]   req_size = 2'b00;
    logic         req_unsigned = 1'b0;
    logic [B-1:0] req_addr = '0;
    logic [B-1:0] req_wdata = '0;
    logic         rsp_valid;
    logic [B-1:0] rsp_rdata;
    logic         rsp_misalign;
    logic         busy;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_addr;
    logic [B-1:0] mem_wdata;
    logic [B-1:0] mem_rdata = '0;

    logic [B-1:0] ram [2**W];
    logic [B-1:0] ref_mem [2**W];
    logic         bd_we = 1'b0;
    logic [W-1:0] bd_idx = '0;
    logic [B-1:0] bd_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.B(B), .W(W)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_write    (req_write),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_misalign (rsp_misalign),
        .o_busy         (busy),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    // Registered-read RAM; read data is zero in any cycle not following a read strobe.
    always @(posedge clk) begin
        if (bd_we)          ram[bd_idx]   <= bd_data;
        else if (mem_write) ram[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= ram[mem_addr];
        else          mem_rdata <= '0;
    end

    function automatic string fmt(input obs_t o);
        return $sformatf("lat=%0d busy=%0d rdata=%h mis=%0d rd=%0d wr=%0d both=%0d",
                         o.lat, o.busy, o.rdata, o.mis, o.nrd, o.nwr, o.both);
    endfunction

    task automatic bd_write(input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = idx[W-1:0];
        bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Reference: apply one request to the word array and predict everything observable.
    task automatic model_txn(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd, output obs_t e);
        int idx, nbytes, off;
        logic [31:0] mask, v;
        idx    = int'(addr[6:2]);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off    = int'(addr[1:0]) - (int'(addr[1:0]) % nbytes);
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        e = '0;
        if (MIS_EN && (int'(addr[1:0]) % nbytes != 0)) begin
            e.lat  = 4'd1;
            e.busy = 4'd1;
            e.mis  = 1'b1;
        end else if (wr) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            e.nwr  = 4'd1;
            e.nrd  = (nbytes == 4) ? 4'd0 : 4'd1;
            e.lat  = (nbytes == 4) ? 4'd2 : 4'd4;
            e.busy = e.lat;
        end else begin
            v = (ref_mem[idx] >> (8 * off)) & mask;
            if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
            e.rdata = v;
            e.nrd   = 4'd1;
            e.lat   = 4'd3;
            e.busy  = 4'd3;
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // Observe cycles after an accept edge until the response pulse, bounded at 12 cycles.
    task automatic collect(input bit hold, output obs_t o);
        o = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            if (mem_read)              o.nrd  = o.nrd + 4'd1;
            if (mem_write)             o.nwr  = o.nwr + 4'd1;
            if (mem_read && mem_write) o.both = 1'b1;
            if (busy)                  o.busy = o.busy + 4'd1;
            if (rsp_valid) begin
                o.lat   = 4'(n);
                o.rdata = rsp_rdata;
                o.mis   = rsp_misalign;
                break;
            end
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output obs_t o);
        @(negedge clk);
        drive(wr, sz, uns, addr, wd);
        @(posedge clk);
        collect(1'b0, o);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, busy, rsp_valid, rsp_misalign, mem_read, mem_write} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {req_ready, busy, rsp_valid, rsp_misalign, mem_read, mem_write});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all zero",
                     rsp_rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t vecs [7];
        obs_t o, e;
        vecs[0] = '{1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 32'hFFFF_FF80};
        vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 32'h0000_0080};
        vecs[2] = '{1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'h0000_1234};
        vecs[3] = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h80FF_1234};
        vecs[4] = '{1'b1, 2'b00, 1'b0, 32'h05, 32'hAB, 32'h0};
        vecs[5] = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 32'h0};
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        vecs[6] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0};
`else
        vecs[6] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h1122_AB44};
`endif
        bd_write(1, 32'h80FF_1234);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) bd_write(1, 32'h1122_3344);
            model_txn(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, e);
            issue(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL directed[%0d]: got %s expected %s", i, fmt(o), fmt(e));
            end
            checks++;
            if (o.rdata !== vecs[i].lit) begin
                failures++;
                $display("FAIL directed_rdata[%0d]: got %h expected %h", i, o.rdata, vecs[i].lit);
            end
        end
        checks++;
        if (ram[1] !== 32'h1122_AB44) begin
            failures++;
            $display("FAIL sb_merge_word: got %h expected 1122ab44", ram[1]);
        end
        checks++;
        if (ram[2] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL sw_word: got %h expected deadbeef", ram[2]);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int wr_seen, rsp_seen;
        wr_seen  = 0;
        rsp_seen = 0;
        bd_write(9, 32'hCAFE_F00D);
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h25, 32'h5A);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_write) wr_seen++;
        @(negedge clk);
        if (mem_write) wr_seen++;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_write) wr_seen++;
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if ({mem_addr, rsp_rdata, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL rmw_reset_regs: got addr=%h rdata=%h wdata=%h expected zero",
                     mem_addr, rsp_rdata, mem_wdata);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write) wr_seen++;
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (wr_seen != 0 || rsp_seen != 0) begin
            failures++;
            $display("FAIL rmw_reset_abort: got writes=%0d rsps=%0d expected 0 0", wr_seen, rsp_seen);
        end
        checks++;
        if (ram[9] !== ref_mem[9]) begin
            failures++;
            $display("FAIL rmw_reset_ram: got %h expected %h", ram[9], ref_mem[9]);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmw_reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, ea, eb;
        logic [31:0] wd_b;
        wd_b = $urandom;
        model_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, ea);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        #1 drive(1'b1, 2'b10, 1'b0, 32'h44, wd_b);
        collect(1'b1, o);
        checks++;
        if (o !== ea) begin
            failures++;
            $display("FAIL b2b_first: got %s expected %s", fmt(o), fmt(ea));
        end
        @(negedge clk);
        checks++;
        if ({req_ready, busy, mem_write} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_idle_gap: got ready/busy/write=%b expected 100",
                     {req_ready, busy, mem_write});
        end
        model_txn(1'b1, 2'b10, 1'b0, 32'h44, wd_b, eb);
        @(posedge clk);
        collect(1'b0, o);
        checks++;
        if (o !== eb) begin
            failures++;
            $display("FAIL b2b_second: got %s expected %s", fmt(o), fmt(eb));
        end
        checks++;
        if (ram[17] !== ref_mem[17]) begin
            failures++;
            $display("FAIL b2b_ram: got %h expected %h", ram[17], ref_mem[17]);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic        wr, uns;
        logic [1:0]  sz;
        logic [31:0] addr, wd;
        int idx, bad;
        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = $urandom;
            wd   = $urandom;
            model_txn(wr, sz, uns, addr, wd, e);
            issue(wr, sz, uns, addr, wd, o);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random[%0d] wr=%0d sz=%0d uns=%0d addr=%h: got %s expected %s",
                         i, wr, sz, uns, addr, fmt(o), fmt(e));
            end
            idx = int'(addr[6:2]);
            checks++;
            if (ram[idx] !== ref_mem[idx]) begin
                failures++;
                $display("FAIL random_ram[%0d] word %0d: got %h expected %h", i, idx, ram[idx], ref_mem[idx]);
            end
        end
        bad = 0;
        for (int k = 0; k < 2**W; k++) if (ram[k] !== ref_mem[k]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL final_ram: got %0d differing words expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        for (int k = 0; k < 2**W; k++) bd_write(k, $urandom);
        test_directed();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
